ascon_perm_seq: RTL

Multi-cycle Ascon permutation engine (p^a, a = 1..12) for the RV64 Ascon accelerator path. It holds the 320-bit state as five 64-bit words. Each round it applies constant addition and the bitsliced 5-bit S-box in one cycle, then the sigma linear layer one word per cycle through a single shared sigma datapath. This block sits directly upstream of the sigma linear-layer function and sequences it; the result returns over a valid/ready response channel.

---
 rtl/ascon_perm_seq_if.sv | 22 ++
 rtl/ascon_perm_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_seq_if.sv
// Request/response channel of the Ascon permutation engine.
// The master issues states and consumes results; the slave is the engine.
interface ascon_perm_seq_if;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_rounds;
    logic [319:0] req_state;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [319:0] rsp_state;
    logic         busy;

    modport master (
        output req_valid, req_rounds, req_state, rsp_ready,
        input  req_ready, rsp_valid, rsp_state, busy
    );

    modport slave (
        input  req_valid, req_rounds, req_state, rsp_ready,
        output req_ready, rsp_valid, rsp_state, busy
    );
endinterface

// File: rtl/ascon_perm_seq.sv
// Multi-cycle Ascon permutation p^a: one cycle of constant addition plus S-box,
// then five cycles of the sigma linear layer through one shared word datapath.
module ascon_perm_seq #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    ascon_perm_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SBOX = 2'd1,
        LIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_R      = 4'(MAX_ROUNDS);
    localparam logic [3:0] LAST_ROUND = MAX_R - 4'd1;

    state_t       state_r;
    logic [63:0]  x_r [5];
    logic [3:0]   round_r;
    logic [2:0]   word_r;
    logic         req_ready_r;
    logic         rsp_valid_r;
    logic         busy_r;

    logic [63:0]  sbox_x2_s;
    logic [319:0] sbox_out_s;
    logic [63:0]  lin_in_s;
    logic [63:0]  lin_out_s;
    logic         rounds_ok_s;

    // Rotate right by a full 6-bit amount (61 and 41 must not wrap to 5 bits).
    function automatic logic [63:0] ror64(input logic [63:0] v, input logic [5:0] s);
        logic [127:0] d;
        d = {v, v} >> s;
        return d[63:0];
    endfunction

    // Bitsliced 5-bit S-box; returns {x4,x3,x2,x1,x0}.
    function automatic logic [319:0] sbox_layer(input logic [63:0] a0, input logic [63:0] a1,
                                                input logic [63:0] a2, input logic [63:0] a3,
                                                input logic [63:0] a4);
        logic [63:0] s0, s1, s2, s3, s4;
        logic [63:0] t0, t1, t2, t3, t4;
        s0 = a0 ^ a4;
        s1 = a1;
        s2 = a2 ^ a1;
        s3 = a3;
        s4 = a4 ^ a3;
        t0 = ~s0 & s1;
        t1 = ~s1 & s2;
        t2 = ~s2 & s3;
        t3 = ~s3 & s4;
        t4 = ~s4 & s0;
        s0 = s0 ^ t1;
        s1 = s1 ^ t2;
        s2 = s2 ^ t3;
        s3 = s3 ^ t4;
        s4 = s4 ^ t0;
        s1 = s1 ^ s0;
        s0 = s0 ^ s4;
        s3 = s3 ^ s2;
        s2 = ~s2;
        return {s4, s3, s2, s1, s0};
    endfunction

    // Sigma of word w with that word's rotation pair.
    function automatic logic [63:0] sigma_word(input logic [63:0] v, input logic [2:0] w);
        logic [5:0] ra;
        logic [5:0] rb;
        case (w)
            3'd0:    begin ra = 6'd19; rb = 6'd28; end
            3'd1:    begin ra = 6'd61; rb = 6'd39; end
            3'd2:    begin ra = 6'd1;  rb = 6'd6;  end
            3'd3:    begin ra = 6'd10; rb = 6'd17; end
            3'd4:    begin ra = 6'd7;  rb = 6'd41; end
            default: begin ra = 6'd0;  rb = 6'd0;  end
        endcase
        return v ^ ror64(v, ra) ^ ror64(v, rb);
    endfunction

    // Round-constant injection, S-box layer and sigma on the selected word.
    always_comb begin
        sbox_x2_s   = x_r[2] ^ {56'h0, 4'hF - round_r, round_r};
        sbox_out_s  = sbox_layer(x_r[0], x_r[1], sbox_x2_s, x_r[3], x_r[4]);
        rounds_ok_s = (bus.req_rounds != 4'd0) && (bus.req_rounds <= MAX_R);
        case (word_r)
            3'd0:    lin_in_s = x_r[0];
            3'd1:    lin_in_s = x_r[1];
            3'd2:    lin_in_s = x_r[2];
            3'd3:    lin_in_s = x_r[3];
            3'd4:    lin_in_s = x_r[4];
            default: lin_in_s = 64'h0;
        endcase
        lin_out_s = sigma_word(lin_in_s, word_r);
    end

    // Sequencer FSM with state words and registered handshake outputs.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_r     <= IDLE;
            for (int k = 0; k < 5; k++) x_r[k] <= 64'h0;
            round_r     <= 4'd0;
            word_r      <= 3'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        for (int k = 0; k < 5; k++) x_r[k] <= bus.req_state[64*k +: 64];
                        round_r     <= MAX_R - bus.req_rounds;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        // Out-of-range round counts pass the state straight through.
                        if (rounds_ok_s) begin
                            state_r <= SBOX;
                        end else begin
                            state_r     <= DONE;
                            rsp_valid_r <= 1'b1;
                        end
                    end
                end
                SBOX: begin
                    for (int k = 0; k < 5; k++) x_r[k] <= sbox_out_s[64*k +: 64];
                    word_r  <= 3'd0;
                    state_r <= LIN;
                end
                LIN: begin
                    case (word_r)
                        3'd0:    x_r[0] <= lin_out_s;
                        3'd1:    x_r[1] <= lin_out_s;
                        3'd2:    x_r[2] <= lin_out_s;
                        3'd3:    x_r[3] <= lin_out_s;
                        3'd4:    x_r[4] <= lin_out_s;
                        default: x_r[0] <= x_r[0];
                    endcase
                    word_r <= word_r + 3'd1;
                    if (word_r == 3'd4) begin
                        if (round_r == LAST_ROUND) begin
                            state_r     <= DONE;
                            rsp_valid_r <= 1'b1;
                        end else begin
                            round_r <= round_r + 4'd1;
                            state_r <= SBOX;
                        end
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.busy      = busy_r;
    assign bus.rsp_state = {x_r[4], x_r[3], x_r[2], x_r[1], x_r[0]};

endmodule
